// File: rtl/sm_reg_shadow_pkg.sv
// Shared defaults and scan FSM state encoding for the debug register shadow.
package sm_reg_shadow_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_ISSUE  = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;
endpackage

// File: rtl/sm_shadow_ram.sv
// Shadow register file: data plus changed bit per entry, one write port, one registered read port.
module sm_shadow_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rchg
);
  localparam int DEPTH = 2**ADDR_W;

  // MSB of each entry is the changed flag, low DATA_W bits the data
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rchg;
  logic [DATA_W:0]   w_old;

  assign w_old = r_mem[i_waddr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
      r_rchg  <= 1'b0;
    end else begin
      if (i_we) r_mem[i_waddr] <= {(i_wdata != w_old[DATA_W-1:0]), i_wdata};
      // read uses the pre-write contents when addresses collide
      r_rdata <= r_mem[i_raddr][DATA_W-1:0];
      r_rchg  <= r_mem[i_raddr][DATA_W];
    end
  end

  assign o_rdata = r_rdata;
  assign o_rchg  = r_rchg;
endmodule

// File: rtl/sm_reg_shadow.sv
// Scans the CPU register-file debug port into a shadow copy and serves debug-screen reads
// from it with 1-cycle latency; freeze holds a sweep-consistent snapshot.
module sm_reg_shadow
  import sm_reg_shadow_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SCAN_GAP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  output logic [ADDR_W-1:0] cpuRegAddr,
  input  logic [DATA_W-1:0] cpuRegData,
  input  logic [ADDR_W-1:0] regAddr,
  output logic [DATA_W-1:0] regData,
  output logic              regChanged,
  output logic              sweepDone,
  output logic              frozen
);
  localparam logic [ADDR_W-1:0] IDX_MAX  = '1;
  localparam logic [3:0]        GAP_LAST = 4'(SCAN_GAP - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic [3:0]        r_gap;
  logic              w_last;
  logic              w_we;

  assign w_last = (r_idx == IDX_MAX);
  assign w_we   = (r_state == S_SAMPLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ISSUE:  w_next = (SCAN_GAP > 0) ? S_WAIT : S_SAMPLE;
      S_WAIT:   if (r_gap == GAP_LAST) w_next = S_SAMPLE;
      // freeze only matters at the end of a sweep so the snapshot is whole
      S_SAMPLE: w_next = (w_last && freeze) ? S_HOLD : S_ISSUE;
      S_HOLD:   if (!freeze) w_next = S_ISSUE;
      default:  w_next = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_ISSUE;
      r_idx      <= '0;
      r_gap      <= '0;
      r_cpu_addr <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_ISSUE: begin
          r_cpu_addr <= r_idx;
          r_gap      <= '0;
        end
        S_WAIT:   r_gap <= r_gap + 4'd1;
        S_SAMPLE: r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  sm_shadow_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (cpuRegData),
    .i_raddr (regAddr),
    .o_rdata (regData),
    .o_rchg  (regChanged)
  );

  assign cpuRegAddr = r_cpu_addr;
  assign sweepDone  = w_we && w_last;
  assign frozen     = (r_state == S_HOLD);
endmodule

// File: tb/tb_sm_reg_shadow.sv
// Self-checking bench for sm_reg_shadow: sweep-level reference model, vector table and timing checks.
module tb_sm_reg_shadow;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, freeze;
  logic [AW-1:0] cpuRegAddr, regAddr;
  logic [DW-1:0] cpuRegData, regData;
  logic          regChanged, sweepDone, frozen;

  logic          rst3_n, freeze3;
  logic [AW-1:0] cpuRegAddr3, regAddr3;
  logic [DW-1:0] cpuRegData3, regData3;
  logic          regChanged3, sweepDone3, frozen3;

  logic [DW-1:0] cpu [N];
  assign cpuRegData  = cpu[cpuRegAddr];
  assign cpuRegData3 = cpu[cpuRegAddr3];

  sm_reg_shadow #(.ADDR_W(AW), .DATA_W(DW), .SCAN_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .cpuRegAddr(cpuRegAddr),
    .cpuRegData(cpuRegData), .regAddr(regAddr), .regData(regData),
    .regChanged(regChanged), .sweepDone(sweepDone), .frozen(frozen));

  sm_reg_shadow #(.ADDR_W(AW), .DATA_W(DW), .SCAN_GAP(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .freeze(freeze3), .cpuRegAddr(cpuRegAddr3),
    .cpuRegData(cpuRegData3), .regAddr(regAddr3), .regData(regData3),
    .regChanged(regChanged3), .sweepDone(sweepDone3), .frozen(frozen3));

  // Sweep-level reference: after each full sweep the shadow equals the CPU file,
  // and a changed flag is set where the CPU value differs from the previous sweep.
  logic [DW-1:0] m_sh  [N];
  logic          m_chg [N];

  int errors = 0;
  int checks = 0;
  int frz_cnt = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          chg;
  } vec_t;
  vec_t tv [6];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frozen) frz_cnt++;
  endtask

  task automatic model_sweep();
    for (int i = 0; i < N; i++) begin
      m_chg[i] = (cpu[i] != m_sh[i]);
      m_sh[i]  = cpu[i];
    end
  endtask

  task automatic wait_done(input string nm, input int pre, input int exp);
    int n;
    n = pre;
    do begin
      tick();
      n++;
    end while (!sweepDone && n < 400);
    chk(nm, 32'(n), 32'(exp));
    if (sweepDone) model_sweep();
  endtask

  // precondition: scanner at the start of a sweep
  task automatic go_hold(input string nm);
    freeze = 1'b1;
    wait_done(nm, 0, 63);
    tick();
    chk({nm, "_frozen"}, 32'(frozen), 32'd1);
  endtask

  task automatic release_hold(input string nm);
    freeze = 1'b0;
    tick();
    chk(nm, 32'(frozen), 32'd0);
  endtask

  task automatic check_all(input string nm);
    int a;
    for (int i = 0; i < N; i++) begin
      a = (i * 13 + 5) % N;
      regAddr = AW'(a);
      tick();
      chk({nm, "_data"}, regData, m_sh[a]);
      chk({nm, "_chg"}, 32'(regChanged), 32'(m_chg[a]));
    end
  endtask

  initial begin
    int n, first;
    logic [DW-1:0] oldv, newv;

    tv[0] = '{addr: 5'd0,  data: 32'h0000_0000, chg: 1'b0};
    tv[1] = '{addr: 5'd5,  data: 32'h0000_0505, chg: 1'b0};
    tv[2] = '{addr: 5'd7,  data: 32'hDEAD_BEEF, chg: 1'b1};
    tv[3] = '{addr: 5'd6,  data: 32'h0000_0606, chg: 1'b0};
    tv[4] = '{addr: 5'd8,  data: 32'h0000_0808, chg: 1'b0};
    tv[5] = '{addr: 5'd31, data: 32'h0000_1F1F, chg: 1'b0};

    rst_n = 1'b0; rst3_n = 1'b0; freeze = 1'b0; freeze3 = 1'b0;
    regAddr = '0; regAddr3 = 5'd2;
    for (int i = 0; i < N; i++) begin
      cpu[i]   = DW'(i) * 32'h0101;
      m_sh[i]  = '0;
      m_chg[i] = 1'b0;
    end
    tick(); tick();
    chk("rst_cpuaddr", 32'(cpuRegAddr), 32'd0);
    chk("rst_data", regData, 32'd0);
    chk("rst_chg", 32'(regChanged), 32'd0);
    chk("rst_done", 32'(sweepDone), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    rst_n = 1'b1;

    // 1: first sweep, sweepDone in cycle 64, then read entry 5
    wait_done("t1_done_cycle", 0, 63);
    regAddr = 5'd5;
    tick();
    chk("t1_data5", regData, 32'h0000_0505);
    chk("t1_chg5", 32'(regChanged), 32'd1);
    chk("t1_done_pulse", 32'(sweepDone), 32'd0);

    // 2: unchanged sweep clears all flags; then only entry 7 changes
    go_hold("t2_sweep2");
    check_all("t2_unchanged");
    cpu[7] = 32'hDEAD_BEEF;
    release_hold("t2_release");
    go_hold("t2_sweep3");
    foreach (tv[k]) begin
      regAddr = tv[k].addr;
      tick();
      chk("t2_vec_data", regData, tv[k].data);
      chk("t2_vec_chg", 32'(regChanged), 32'(tv[k].chg));
    end
    check_all("t2_after7");

    // 3: freeze raised at cycle 10 of a sweep; CPU change invisible while held
    release_hold("t3_release0");
    for (int i = 0; i < 9; i++) tick();
    freeze = 1'b1;
    wait_done("t3_done", 9, 63);
    tick();
    chk("t3_frozen", 32'(frozen), 32'd1);
    oldv = m_sh[3];
    cpu[3] = 32'hA5A5_0003;
    regAddr = 5'd3;
    frz_cnt = 0;
    for (int i = 0; i < 70; i++) tick();
    chk("t3_held_cycles", 32'(frz_cnt), 32'd70);
    chk("t3_held_data", regData, oldv);
    freeze = 1'b0;
    tick();
    chk("t3_unfrozen", 32'(frozen), 32'd0);
    freeze = 1'b1;
    n = 0; first = -1;
    do begin
      tick();
      n++;
      if (first < 0 && regData == 32'hA5A5_0003) first = n;
    end while (!sweepDone && n < 400);
    chk("t3_new_visible", 32'(first), 32'd9);
    chk("t3_done2", 32'(n), 32'd63);
    if (sweepDone) model_sweep();
    tick();
    chk("t3_frozen2", 32'(frozen), 32'd1);

    // 4: freeze pulse over cycles 10..20 must not cause a hold
    release_hold("t4_release");
    frz_cnt = 0;
    n = 0;
    do begin
      freeze = (n >= 9 && n < 20);
      tick();
      n++;
    end while (!sweepDone && n < 400);
    chk("t4_done", 32'(n), 32'd63);
    if (sweepDone) model_sweep();
    freeze = 1'b0;
    tick();
    wait_done("t4_next_sweep", 0, 63);
    chk("t4_never_frozen", 32'(frz_cnt), 32'd0);
    tick();
    go_hold("t4_rehold");

    // 5: read of the entry being sampled returns the pre-write value
    oldv = m_sh[4];
    newv = 32'h1234_5678;
    cpu[4] = newv;
    release_hold("t5_release");
    regAddr = 5'd4;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_same_cycle", regData, oldv);
    tick();
    chk("t5_next_cycle", regData, newv);
    freeze = 1'b1;
    wait_done("t5_done", 11, 63);
    tick();
    chk("t5_frozen", 32'(frozen), 32'd1);

    // randomized CPU updates between frozen sweeps
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) cpu[$urandom_range(0, N-1)] = $urandom;
      release_hold("rnd_release");
      go_hold("rnd_sweep");
      check_all("rnd");
    end

    // 6: SCAN_GAP=3 instance, reset at cycle 40 mid-sweep
    rst3_n = 1'b1;
    for (int i = 0; i < 39; i++) tick();
    chk("t6_pre_data", regData3, cpu[2]);
    rst3_n = 1'b0;
    tick();
    chk("t6_rst_cpuaddr", 32'(cpuRegAddr3), 32'd0);
    chk("t6_rst_data", regData3, 32'd0);
    chk("t6_rst_chg", 32'(regChanged3), 32'd0);
    chk("t6_rst_done", 32'(sweepDone3), 32'd0);
    chk("t6_rst_frozen", 32'(frozen3), 32'd0);
    rst3_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sweepDone3 && n < 600);
    chk("t6_done_cycle", 32'(n), 32'd159);
    tick();
    chk("t6_data2", regData3, cpu[2]);
    chk("t6_chg2", 32'(regChanged3), 32'(cpu[2] != 32'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
